vga_tracker: RTL and testbench

//  640x480@60Hz VGA timing generator on the 25 MHz pixel clock: horizontal/vertical counters,

---
 rtl/vga_tracker.sv | 104 ++++++++++
 tb/tb_vga_tracker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tracker.sv
// 640x480@60Hz VGA timing generator: counters, syncs, active flag, coordinates and frame_tik.
// Optional frame counter output is enabled by defining TRACKER_FRAME_CNT_EN.
module vga_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock_25,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
`ifdef TRACKER_FRAME_CNT_EN
  output logic       frame_tik,
  output logic [7:0] frame_cnt
`else
  output logic       frame_tik
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] TIK_END  = 10'(V_ACTIVE + V_FP - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_tik_q, frame_tik_d;

  // Flags are decoded from the next counter values so they line up with the coordinates.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q >= H_LAST) begin
      h_d = '0;
      v_d = (v_q >= V_LAST) ? 10'd0 : v_q + 10'd1;
    end
    hsync_d     = !((h_d >= HS_START) && (h_d <= HS_END));
    vsync_d     = !((v_d >= VS_START) && (v_d <= VS_END));
    video_on_d  = (h_d < H_VIS) && (v_d < V_VIS);
    frame_tik_d = (v_d >= V_VIS) && (v_d <= TIK_END);
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      video_on_q  <= 1'b1;
      frame_tik_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      video_on_q  <= video_on_d;
      frame_tik_q <= frame_tik_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = video_on_q;
  assign frame_tik = frame_tik_q;
  assign pixel_x   = h_q;
  assign pixel_y   = v_q;

`ifdef TRACKER_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Steps in the same cycle frame_tik rises.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tik_d && !frame_tik_q) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_tracker.sv
// Bench for vga_tracker: a full-size instance checks line timing, a shrunken instance
// (12x8 total, 96-cycle frame) covers whole-frame, mid-frame reset and frame counter behaviour.
module tb_vga_tracker;

  logic       clk;
  logic       rst_l, rst_s;
  logic       l_hs, l_vs, l_von, l_tik;
  logic [9:0] l_x, l_y;
  logic       s_hs, s_vs, s_von, s_tik;
  logic [9:0] s_x, s_y;
`ifdef TRACKER_FRAME_CNT_EN
  logic [7:0] l_fc, s_fc;
`endif

  vga_tracker dut_l (
    .clock_25 (clk),
    .reset    (rst_l),
    .hsync    (l_hs),
    .vsync    (l_vs),
    .video_on (l_von),
    .pixel_x  (l_x),
    .pixel_y  (l_y),
`ifdef TRACKER_FRAME_CNT_EN
    .frame_tik(l_tik),
    .frame_cnt(l_fc)
`else
    .frame_tik(l_tik)
`endif
  );

  // Small geometry: H 6+2+2+2=12 (hsync low x 8..9), V 4+2+1+1=8 (tik y 4..5, vsync y 6).
  vga_tracker #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clock_25 (clk),
    .reset    (rst_s),
    .hsync    (s_hs),
    .vsync    (s_vs),
    .video_on (s_von),
    .pixel_x  (s_x),
    .pixel_y  (s_y),
`ifdef TRACKER_FRAME_CNT_EN
    .frame_tik(s_tik),
    .frame_cnt(s_fc)
`else
    .frame_tik(s_tik)
`endif
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    int f; int x; int y;
    bit hs; bit vs; bit von; bit tik;
  } vec_t;

  vec_t tl[$];
  vec_t ts[$];
  int   checks = 0;
  int   passed = 0;
  int   pos    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic goto(input int tgt);
    if (tgt < pos) begin
      chk("goto_order", pos, tgt);
    end else begin
      repeat (tgt - pos) @(negedge clk);
      pos = tgt;
    end
  endtask

  task automatic add(input bit sm, input int f, input int x, input int y,
                     input bit hs, input bit vs, input bit von, input bit tik);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.von = von; v.tik = tik;
    if (sm) ts.push_back(v);
    else    tl.push_back(v);
  endtask

  int cnt_hs, first_hs, first_voff;
  int cnt_vs, cnt_tik, cnt_ovl, tik_first, tik_last;

  initial begin
    // Full-size vectors: f, x, y, hsync, vsync, video_on, frame_tik
    add(0, 0,   1, 0, 1, 1, 1, 0);
    add(0, 0, 639, 0, 1, 1, 1, 0);
    add(0, 0, 640, 0, 1, 1, 0, 0);
    add(0, 0, 655, 0, 1, 1, 0, 0);
    add(0, 0, 656, 0, 0, 1, 0, 0);
    add(0, 0, 751, 0, 0, 1, 0, 0);
    add(0, 0, 752, 0, 1, 1, 0, 0);
    add(0, 0, 799, 0, 1, 1, 0, 0);
    add(0, 0,   0, 1, 1, 1, 1, 0);
    add(0, 0, 639, 1, 1, 1, 1, 0);
    add(0, 0, 700, 1, 0, 1, 0, 0);
    // Small vectors
    add(1, 0,  1, 0, 1, 1, 1, 0);
    add(1, 0,  5, 3, 1, 1, 1, 0);
    add(1, 0,  6, 3, 1, 1, 0, 0);
    add(1, 0,  8, 3, 0, 1, 0, 0);
    add(1, 0, 11, 3, 1, 1, 0, 0);
    add(1, 0,  0, 4, 1, 1, 0, 1);
    add(1, 0,  9, 5, 0, 1, 0, 1);
    add(1, 0, 11, 5, 1, 1, 0, 1);
    add(1, 0,  0, 6, 1, 0, 0, 0);
    add(1, 0, 11, 6, 1, 0, 0, 0);
    add(1, 0,  0, 7, 1, 1, 0, 0);
    add(1, 0, 11, 7, 1, 1, 0, 0);
    add(1, 1,  0, 0, 1, 1, 1, 0);
    add(1, 1,  1, 0, 1, 1, 1, 0);

    rst_l = 1'b0;
    rst_s = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_hsync",    l_hs,  1);
    chk("rst_vsync",    l_vs,  1);
    chk("rst_video_on", l_von, 1);
    chk("rst_frame_tik", l_tik, 0);
    chk("rst_pixel_x",  l_x,   0);
    chk("rst_pixel_y",  l_y,   0);
`ifdef TRACKER_FRAME_CNT_EN
    chk("rst_frame_cnt", l_fc, 0);
`endif

    rst_l = 1'b1;
    pos = 0;
    foreach (tl[i]) begin
      goto(tl[i].f * 420000 + tl[i].y * 800 + tl[i].x);
      chk($sformatf("L%0d.pixel_x", i),   l_x,   tl[i].x);
      chk($sformatf("L%0d.pixel_y", i),   l_y,   tl[i].y);
      chk($sformatf("L%0d.hsync", i),     l_hs,  tl[i].hs);
      chk($sformatf("L%0d.vsync", i),     l_vs,  tl[i].vs);
      chk($sformatf("L%0d.video_on", i),  l_von, tl[i].von);
      chk($sformatf("L%0d.frame_tik", i), l_tik, tl[i].tik);
    end

    // Whole line 2: hsync low width and edge positions
    goto(2 * 800);
    cnt_hs = 0; first_hs = -1; first_voff = -1;
    for (int i = 0; i < 800; i++) begin
      if (!l_hs) begin
        cnt_hs++;
        if (first_hs < 0) first_hs = int'(l_x);
      end
      if (!l_von && first_voff < 0) first_voff = int'(l_x);
      @(negedge clk);
    end
    pos += 800;
    chk("line_hsync_low_cycles", cnt_hs, 96);
    chk("line_hsync_fall_x", first_hs, 656);
    chk("line_video_off_x", first_voff, 640);
    chk("line_wrap_y", l_y, 3);

    rst_s = 1'b1;
    pos = 0;
    foreach (ts[i]) begin
      goto(ts[i].f * 96 + ts[i].y * 12 + ts[i].x);
      chk($sformatf("S%0d.pixel_x", i),   s_x,   ts[i].x);
      chk($sformatf("S%0d.pixel_y", i),   s_y,   ts[i].y);
      chk($sformatf("S%0d.hsync", i),     s_hs,  ts[i].hs);
      chk($sformatf("S%0d.vsync", i),     s_vs,  ts[i].vs);
      chk($sformatf("S%0d.video_on", i),  s_von, ts[i].von);
      chk($sformatf("S%0d.frame_tik", i), s_tik, ts[i].tik);
    end

    // One whole small frame: vsync and frame_tik extents
    goto(2 * 96);
    cnt_vs = 0; cnt_tik = 0; cnt_ovl = 0; tik_first = -1; tik_last = -1;
    for (int i = 0; i < 96; i++) begin
      if (!s_vs) cnt_vs++;
      if (s_tik) begin
        cnt_tik++;
        if (tik_first < 0) tik_first = i;
        tik_last = i;
        if (s_von) cnt_ovl++;
      end
      @(negedge clk);
    end
    pos += 96;
    chk("frame_vsync_low_cycles", cnt_vs, 12);
    chk("frame_tik_high_cycles", cnt_tik, 24);
    chk("frame_tik_video_overlap", cnt_ovl, 0);
    chk("frame_tik_rise_cycle", tik_first, 48);
    chk("frame_tik_last_cycle", tik_last, 71);
    chk("frame_wrap_x", s_x, 0);
    chk("frame_wrap_y", s_y, 0);

    // Reset mid-frame between clock edges, at (3,2)
    goto(3 * 96 + 2 * 12 + 3);
    chk("mid_pre_x", s_x, 3);
    chk("mid_pre_y", s_y, 2);
    #5 rst_s = 1'b0;
    #1;
    chk("mid_async_x", s_x, 0);
    chk("mid_async_y", s_y, 0);
    chk("mid_async_hsync", s_hs, 1);
    chk("mid_async_vsync", s_vs, 1);
    chk("mid_async_video_on", s_von, 1);
    chk("mid_async_frame_tik", s_tik, 0);
    repeat (3) @(negedge clk);
    chk("mid_hold_x", s_x, 0);
    rst_s = 1'b1;
    pos = 0;
    goto(1);
    chk("mid_restart_x", s_x, 1);
    chk("mid_restart_y", s_y, 0);

`ifdef TRACKER_FRAME_CNT_EN
    chk("fc_after_reset", s_fc, 0);
    for (int k = 0; k < 257; k++) begin
      goto(k * 96 + 47);
      chk($sformatf("fc_before_%0d", k), s_fc, k % 256);
      goto(k * 96 + 48);
      chk($sformatf("fc_after_%0d", k), s_fc, (k + 1) % 256);
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
